// File: rtl/jtframe_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dump_pkg
//  Description : Shared types and constants for the frame-dump trigger:
//                the dump FSM state encoding, the counter width and a
//                saturating-increment helper used by both counters.
//  Revision    : 1.0  initial release
// ============================================================================
package jtframe_dump_pkg;

    // Width of the completed-frame and dumped-frame counters
    localparam int c_cnt_w = 32;

    // All-ones counter value; the counters stop here instead of wrapping
    localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};

    // Dump window FSM
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting to be armed
        ST_ARMED   = 2'd1,  // armed, waiting for the start frame
        ST_DUMPING = 2'd2,  // window open
        ST_DONE    = 2'd3   // window closed until the next reset
    } dump_state_t;

    // Increment that holds at the maximum value rather than rolling over
    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] value);
        logic [c_cnt_w-1:0] result;
        result = (value == c_cnt_max) ? value : value + 1'b1;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_dump_edge.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dump_edge
//  Description : Registered rise/fall detector. Keeps a one-cycle-delayed
//                copy of the input and flags the cycles where the current
//                value differs from it. The copy's reset value is chosen per
//                instance so that a signal sitting at its idle level after
//                reset produces no spurious edge.
//  Revision    : 1.0  initial release
// ============================================================================
module jtframe_dump_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // Delayed copy of the input, preset to the idle level on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= RST_VAL;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule
`default_nettype wire

// File: rtl/jtframe_dump_trig.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dump_trig
//  Description : Frame-dump window trigger. Counts completed frames (vs
//                falling edges), opens a dump window at a chosen frame,
//                optionally only after the ROM download finishes, and closes
//                it after a chosen number of frames or when a new download
//                begins.
//  Revision    : 1.0  initial release
// ============================================================================
module jtframe_dump_trig
    import jtframe_dump_pkg::*;
#(
    parameter int DUMP_START = 0,   // frame at which the window opens, 0 = at once
    parameter int DUMP_LEN   = 0,   // frames to dump, 0 = unlimited
    parameter int LOADROM    = 0    // 1 = arm only after the ROM download ends
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vs,
    input  logic                downloading,
    output logic [c_cnt_w-1:0]  frame_cnt,
    output logic                dump_en,
    output logic                dump_start,
    output logic                dump_stop,
    output logic                done
);

    localparam logic [c_cnt_w-1:0] c_start = c_cnt_w'(DUMP_START);
    localparam logic [c_cnt_w-1:0] c_len   = c_cnt_w'(DUMP_LEN);

    dump_state_t            r_state;
    dump_state_t            w_next;
    logic [c_cnt_w-1:0]     r_frame_cnt;
    logic [c_cnt_w-1:0]     r_dump_cnt;
    logic [c_cnt_w-1:0]     w_dump_inc;
    logic                   r_dump_start;
    logic                   r_dump_stop;
    logic                   w_vs_fall;
    logic                   w_vs_rise_unused;
    logic                   w_dl_rise;
    logic                   w_dl_fall;

    // vs idles high, so its delayed copy resets to 1: a frame ends on vs falling
    jtframe_dump_edge #(
        .RST_VAL (1'b1)
    ) u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (vs),
        .o_rise (w_vs_rise_unused),
        .o_fall (w_vs_fall)
    );

    // downloading idles low; rise = download start, fall = download end
    jtframe_dump_edge #(
        .RST_VAL (1'b0)
    ) u_dl_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (downloading),
        .o_rise (w_dl_rise),
        .o_fall (w_dl_fall)
    );

    assign w_dump_inc = sat_inc(r_dump_cnt);

    // Completed-frame counter: held at zero during a download, saturating otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (downloading) begin
            r_frame_cnt <= '0;
        end else if (w_vs_fall) begin
            r_frame_cnt <= sat_inc(r_frame_cnt);
        end
    end

    // Dumped-frame counter: zero outside the window so it starts clean on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dump_cnt <= '0;
        end else if (r_state != ST_DUMPING) begin
            r_dump_cnt <= '0;
        end else if (w_vs_fall) begin
            r_dump_cnt <= w_dump_inc;
        end
    end

    // Next-state logic for the dump window
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (LOADROM == 0) begin
                    w_next = ST_ARMED;
                end else if (w_dl_fall) begin
                    w_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (DUMP_START == 0) begin
                    w_next = ST_DUMPING;
                end else if (w_vs_fall && (r_frame_cnt == c_start)) begin
                    w_next = ST_DUMPING;
                end
            end
            ST_DUMPING: begin
                // A new download aborts the window and re-arms after it ends
                if ((LOADROM != 0) && w_dl_rise) begin
                    w_next = ST_IDLE;
                end else if ((DUMP_LEN != 0) && w_vs_fall && (w_dump_inc == c_len)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_DONE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register plus start/stop pulses registered on the window transitions
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dump_start <= 1'b0;
            r_dump_stop  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_dump_start <= (w_next == ST_DUMPING) && (r_state != ST_DUMPING);
            r_dump_stop  <= (r_state == ST_DUMPING) && (w_next != ST_DUMPING);
        end
    end

    assign frame_cnt  = r_frame_cnt;
    assign dump_en    = (r_state == ST_DUMPING);
    assign done       = (r_state == ST_DONE);
    assign dump_start = r_dump_start;
    assign dump_stop  = r_dump_stop;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_dump_trig.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtframe_dump_trig
//  Description : Self-checking bench for jtframe_dump_trig. Three instances
//                cover the immediate/unlimited, start-at-frame/limited and
//                ROM-load-gated configurations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jtframe_dump_trig;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: DUMP_START=0, DUMP_LEN=0, LOADROM=0
    logic        rst0, vs0, dl0;
    logic [31:0] fc0;
    logic        en0, st0, sp0, dn0;
    // Instance 1: DUMP_START=5, DUMP_LEN=3, LOADROM=0
    logic        rst1, vs1, dl1;
    logic [31:0] fc1;
    logic        en1, st1, sp1, dn1;
    // Instance 2: DUMP_START=0, DUMP_LEN=3, LOADROM=1
    logic        rst2, vs2, dl2;
    logic [31:0] fc2;
    logic        en2, st2, sp2, dn2;

    jtframe_dump_trig #(.DUMP_START(0), .DUMP_LEN(0), .LOADROM(0)) u0 (
        .clk(clk), .rst(rst0), .vs(vs0), .downloading(dl0), .frame_cnt(fc0),
        .dump_en(en0), .dump_start(st0), .dump_stop(sp0), .done(dn0));

    jtframe_dump_trig #(.DUMP_START(5), .DUMP_LEN(3), .LOADROM(0)) u1 (
        .clk(clk), .rst(rst1), .vs(vs1), .downloading(dl1), .frame_cnt(fc1),
        .dump_en(en1), .dump_start(st1), .dump_stop(sp1), .done(dn1));

    jtframe_dump_trig #(.DUMP_START(0), .DUMP_LEN(3), .LOADROM(1)) u2 (
        .clk(clk), .rst(rst2), .vs(vs2), .downloading(dl2), .frame_cnt(fc2),
        .dump_en(en2), .dump_start(st2), .dump_stop(sp2), .done(dn2));

    typedef struct {
        logic        rst;
        logic        vs;
        logic        dl;
        logic [31:0] cnt;
        logic        en;
        logic        st;
        logic        sp;
        logic        dn;
    } vec_t;

    vec_t tv [22];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic r, input logic v, input logic d,
                                input logic [31:0] c, input logic e,
                                input logic s, input logic p, input logic n);
        vec_t t;
        t.rst = r; t.vs = v; t.dl = d; t.cnt = c;
        t.en = e; t.st = s; t.sp = p; t.dn = n;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int found;
        int stops;

        // DUMP_START=5, DUMP_LEN=3: inputs applied before an edge, outputs seen after it
        tv[0]  = mk(1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[1]  = mk(1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[2]  = mk(1'b0, 1'b0, 1'b0, 32'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[3]  = mk(1'b0, 1'b1, 1'b0, 32'd1,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[4]  = mk(1'b0, 1'b0, 1'b0, 32'd2,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[5]  = mk(1'b0, 1'b1, 1'b0, 32'd2,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[6]  = mk(1'b0, 1'b0, 1'b0, 32'd3,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[7]  = mk(1'b0, 1'b1, 1'b0, 32'd3,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[8]  = mk(1'b0, 1'b0, 1'b0, 32'd4,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[9]  = mk(1'b0, 1'b1, 1'b0, 32'd4,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[10] = mk(1'b0, 1'b0, 1'b0, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[11] = mk(1'b0, 1'b1, 1'b0, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0);
        tv[12] = mk(1'b0, 1'b0, 1'b0, 32'd6,  1'b1, 1'b1, 1'b0, 1'b0);
        tv[13] = mk(1'b0, 1'b1, 1'b0, 32'd6,  1'b1, 1'b0, 1'b0, 1'b0);
        tv[14] = mk(1'b0, 1'b0, 1'b0, 32'd7,  1'b1, 1'b0, 1'b0, 1'b0);
        tv[15] = mk(1'b0, 1'b1, 1'b0, 32'd7,  1'b1, 1'b0, 1'b0, 1'b0);
        tv[16] = mk(1'b0, 1'b0, 1'b0, 32'd8,  1'b1, 1'b0, 1'b0, 1'b0);
        tv[17] = mk(1'b0, 1'b1, 1'b0, 32'd8,  1'b1, 1'b0, 1'b0, 1'b0);
        tv[18] = mk(1'b0, 1'b0, 1'b0, 32'd9,  1'b0, 1'b0, 1'b1, 1'b1);
        tv[19] = mk(1'b0, 1'b1, 1'b0, 32'd9,  1'b0, 1'b0, 1'b0, 1'b1);
        tv[20] = mk(1'b0, 1'b0, 1'b0, 32'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        tv[21] = mk(1'b0, 1'b1, 1'b0, 32'd10, 1'b0, 1'b0, 1'b0, 1'b1);

        rst0 = 1'b1; vs0 = 1'b1; dl0 = 1'b0;
        rst1 = 1'b1; vs1 = 1'b1; dl1 = 1'b0;
        rst2 = 1'b1; vs2 = 1'b1; dl2 = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_cnt",   fc0, 32'd0);
        chk("rst_en",    {31'd0, en0}, 32'd0);
        chk("rst_start", {31'd0, st0}, 32'd0);
        chk("rst_stop",  {31'd0, sp0}, 32'd0);
        chk("rst_done",  {31'd0, dn0}, 32'd0);

        // Start-at-frame-5, three-frame window
        for (int i = 0; i < 22; i++) begin
            rst1 = tv[i].rst; vs1 = tv[i].vs; dl1 = tv[i].dl;
            step();
            chk($sformatf("tv%0d_cnt", i),   fc1, tv[i].cnt);
            chk($sformatf("tv%0d_en", i),    {31'd0, en1}, {31'd0, tv[i].en});
            chk($sformatf("tv%0d_start", i), {31'd0, st1}, {31'd0, tv[i].st});
            chk($sformatf("tv%0d_stop", i),  {31'd0, sp1}, {31'd0, tv[i].sp});
            chk($sformatf("tv%0d_done", i),  {31'd0, dn1}, {31'd0, tv[i].dn});
        end

        // Immediate start: dump_start two cycles after rst falls
        rst0 = 1'b0;
        step();
        chk("imm_start_c1", {31'd0, st0}, 32'd0);
        chk("imm_en_c1",    {31'd0, en0}, 32'd0);
        step();
        chk("imm_start_c2", {31'd0, st0}, 32'd1);
        chk("imm_en_c2",    {31'd0, en0}, 32'd1);
        step();
        chk("imm_start_c3", {31'd0, st0}, 32'd0);

        // Unlimited window stays open for 100 frames
        bad = 0;
        for (int f = 0; f < 100; f++) begin
            vs0 = 1'b0;
            step();
            if (!en0 || st0 || sp0 || dn0) bad++;
            vs0 = 1'b1;
            step();
            if (!en0 || st0 || sp0 || dn0) bad++;
        end
        chk("unlim_bad_cycles", bad, 0);
        chk("unlim_cnt",  fc0, 32'd100);
        chk("unlim_done", {31'd0, dn0}, 32'd0);

        // Saturation at all-ones
        @(negedge clk);
        force u0.r_frame_cnt = 32'hFFFF_FFFE;
        #1;
        release u0.r_frame_cnt;
        step();
        chk("sat_preset", fc0, 32'hFFFF_FFFE);
        for (int f = 0; f < 3; f++) begin
            vs0 = 1'b0;
            step();
            chk($sformatf("sat_edge%0d", f), fc0, 32'hFFFF_FFFF);
            vs0 = 1'b1;
            step();
        end

        // Reset in the middle of an open window
        chk("midrst_pre_en", {31'd0, en0}, 32'd1);
        rst0 = 1'b1;
        step();
        chk("midrst_en",    {31'd0, en0}, 32'd0);
        chk("midrst_start", {31'd0, st0}, 32'd0);
        chk("midrst_stop",  {31'd0, sp0}, 32'd0);
        chk("midrst_done",  {31'd0, dn0}, 32'd0);
        chk("midrst_cnt",   fc0, 32'd0);
        rst0 = 1'b0;
        step();
        chk("midrst_stop_after", {31'd0, sp0}, 32'd0);

        // ROM-load gating: no arming before or during the download
        rst2 = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("ld_no_arm_pre", {31'd0, en2}, 32'd0);
        dl2 = 1'b1;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            vs2 = ((c % 200) == 100) ? 1'b0 : 1'b1;
            step();
            if (en2 || st2 || fc2 != 32'd0) bad++;
        end
        chk("ld_during_bad", bad, 0);
        chk("ld_during_cnt", fc2, 32'd0);
        dl2 = 1'b0;
        found = 0;
        step();
        if (st2) found++;
        step();
        if (st2) found++;
        chk("ld_start_within2", found, 1);
        chk("ld_en", {31'd0, en2}, 32'd1);

        // Download restarting on the vs edge that would complete the window
        for (int f = 0; f < 2; f++) begin
            vs2 = 1'b0;
            step();
            vs2 = 1'b1;
            step();
        end
        chk("abort_pre_cnt", fc2, 32'd2);
        chk("abort_pre_en",  {31'd0, en2}, 32'd1);
        vs2 = 1'b0;
        dl2 = 1'b1;
        step();
        chk("abort_stop", {31'd0, sp2}, 32'd1);
        chk("abort_en",   {31'd0, en2}, 32'd0);
        chk("abort_done", {31'd0, dn2}, 32'd0);
        chk("abort_cnt",  fc2, 32'd0);
        vs2 = 1'b1;
        stops = 0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (sp2) stops++;
            if (dn2 || en2) bad++;
        end
        chk("abort_extra_stops", stops, 0);
        chk("abort_idle_bad",    bad, 0);
        chk("abort_post_cnt",    fc2, 32'd0);

        // Re-arm after the second download ends
        dl2 = 1'b0;
        step();
        step();
        chk("rearm_start", {31'd0, st2}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog keeps the run bounded
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
